ssd_sequence_entry: RTL

SSD_SEQUENCE_ENTRY -- requirements
Module: ssd_sequence_entry

---
 rtl/ssd_pkg.sv | 42 ++++
 rtl/ssd_symbol_enc.sv | 23 ++
 rtl/ssd_sequence_entry.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment sequence-entry game block.
// Holds the one-cold symbol codes, their active-low glyphs, the error and
// blank glyphs, the FSM state encoding and the symbol-advance helper.
package ssd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_ENTRY = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One-cold symbol codes, in entry advance order
  localparam logic [3:0] SYM_0 = 4'b1110;
  localparam logic [3:0] SYM_1 = 4'b1101;
  localparam logic [3:0] SYM_2 = 4'b1011;
  localparam logic [3:0] SYM_3 = 4'b0111;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_0     = 7'b1111110;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b1110111;
  localparam logic [6:0] GLYPH_3     = 7'b1001111;
  localparam logic [6:0] GLYPH_ERR   = 7'b0100001;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  localparam int unsigned SEC_W = 4;

  // Cycle a symbol to the next one in the entry ring; illegal codes restart the ring
  function automatic logic [3:0] next_symbol(input logic [3:0] sym);
    logic [3:0] nxt;
    case (sym)
      SYM_0:   nxt = SYM_1;
      SYM_1:   nxt = SYM_2;
      SYM_2:   nxt = SYM_3;
      SYM_3:   nxt = SYM_0;
      default: nxt = SYM_0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ssd_symbol_enc.sv
// Combinational one-cold symbol to active-low seven-segment glyph encoder.
// Ports:
//   code    in  4  one-cold symbol code
//   glyph_c out 7  active-low segments; error glyph for any non one-cold code
module ssd_symbol_enc
  import ssd_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] glyph_c
);

  always_comb begin
    glyph_c = GLYPH_ERR;
    case (code)
      SYM_0:   glyph_c = GLYPH_0;
      SYM_1:   glyph_c = GLYPH_1;
      SYM_2:   glyph_c = GLYPH_2;
      SYM_3:   glyph_c = GLYPH_3;
      default: glyph_c = GLYPH_ERR;
    endcase
  end

endmodule

// File: rtl/ssd_sequence_entry.sv
// Memory-game round on a seven-segment display: show a challenge sequence
// for SHOW_SECS seconds, then let the player enter a sequence digit by digit
// with move/prev/next buttons and submit it.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   sequence_in          challenge, 4 bits per digit, digit 0 rightmost
//   game_state           controller state; TRIGGER_STATE starts a round
//   one_sec              single-cycle pulse once per second
//   button_move/prev/next  debounced button levels
//   abort                level; cancels an active round
//   sevseg               active-low segments, 7 bits per digit
//   sequence_out         entered sequence, same layout as sequence_in
//   submit_valid         one-cycle pulse when sequence_out is complete
//   cursor               index of the digit under edit
module ssd_sequence_entry
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SHOW_SECS     = 3,
  parameter logic [7:0]  TRIGGER_STATE = 8'h10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] sequence_in,
  input  logic [7:0]              game_state,
  input  logic                    one_sec,
  input  logic                    button_move,
  input  logic                    button_prev,
  input  logic                    button_next,
  input  logic                    abort,
  output logic [7*NUM_DIGITS-1:0] sevseg,
  output logic [4*NUM_DIGITS-1:0] sequence_out,
  output logic                    submit_valid,
  output logic [2:0]              cursor
);

  localparam int unsigned SEQ_W = 4 * NUM_DIGITS;
  localparam int unsigned SEG_W = 7 * NUM_DIGITS;
  localparam logic [2:0]       CUR_MAX   = 3'(NUM_DIGITS - 1);
  localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(SHOW_SECS - 1);
  localparam logic [SEG_W-1:0] ALL_BLANK = {NUM_DIGITS{GLYPH_BLANK}};
  localparam logic [SEG_W-1:0] ALL_SYM0  = {NUM_DIGITS{GLYPH_0}};
  localparam logic [SEQ_W-1:0] SEQ_SYM0  = {NUM_DIGITS{SYM_0}};

  state_t           state;
  logic [SEC_W-1:0] sec_cnt;
  logic             blink;
  logic             move_q, prev_q, next_q;

  logic             move_e, prev_e, next_e;
  logic [SEQ_W-1:0] seq_nxt;
  logic [2:0]       cur_nxt;
  logic             blink_nxt;
  logic             go_done;
  logic [SEQ_W-1:0] enc_in;
  logic [SEG_W-1:0] glyph_flat;
  logic [SEG_W-1:0] entry_disp;

  // Entry-mode next values: one button action per cycle, next > prev > move
  always_comb begin
    move_e    = button_move & ~move_q;
    prev_e    = button_prev & ~prev_q;
    next_e    = button_next & ~next_q;
    seq_nxt   = sequence_out;
    cur_nxt   = cursor;
    blink_nxt = blink ^ one_sec;
    go_done   = 1'b0;
    if (next_e) begin
      if (cursor == 3'd0) go_done = 1'b1;
      else                cur_nxt = cursor - 3'd1;
    end else if (prev_e) begin
      if (cursor != CUR_MAX) cur_nxt = cursor + 3'd1;
    end else if (move_e) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (3'(i) == cursor) seq_nxt[4*i +: 4] = next_symbol(sequence_out[4*i +: 4]);
      end
    end
  end

  // Shared encoders: challenge during SHOW, the entry sequence otherwise
  always_comb begin
    enc_in = (state == ST_SHOW) ? sequence_in : seq_nxt;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    ssd_symbol_enc u_enc (
      .code    (enc_in[4*g +: 4]),
      .glyph_c (glyph_flat[7*g +: 7])
    );
  end

  // Entry display with the cursor digit blanked while the blink flag is set
  always_comb begin
    entry_disp = glyph_flat;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (blink_nxt && (3'(i) == cur_nxt)) entry_disp[7*i +: 7] = GLYPH_BLANK;
    end
  end

  // Round FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      sevseg       <= ALL_BLANK;
      sequence_out <= '1;
      submit_valid <= 1'b0;
      cursor       <= 3'd0;
      sec_cnt      <= '0;
      blink        <= 1'b0;
      move_q       <= 1'b0;
      prev_q       <= 1'b0;
      next_q       <= 1'b0;
    end else begin
      move_q       <= button_move;
      prev_q       <= button_prev;
      next_q       <= button_next;
      submit_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          sevseg  <= ALL_BLANK;
          sec_cnt <= '0;
          if (game_state == TRIGGER_STATE) state <= ST_SHOW;
        end
        ST_SHOW: begin
          if (abort) begin
            state  <= ST_IDLE;
            sevseg <= ALL_BLANK;
          end else begin
            sevseg <= glyph_flat;
            if (one_sec) begin
              if (sec_cnt == SEC_LAST) begin
                // The final pulse is consumed here and does not toggle blink
                state        <= ST_ENTRY;
                sevseg       <= ALL_SYM0;
                sequence_out <= SEQ_SYM0;
                cursor       <= CUR_MAX;
                blink        <= 1'b0;
                sec_cnt      <= '0;
              end else begin
                sec_cnt <= sec_cnt + SEC_W'(1);
              end
            end
          end
        end
        ST_ENTRY: begin
          if (abort) begin
            state  <= ST_IDLE;
            sevseg <= ALL_BLANK;
          end else begin
            sequence_out <= seq_nxt;
            cursor       <= cur_nxt;
            blink        <= blink_nxt;
            sevseg       <= entry_disp;
            if (go_done) begin
              state        <= ST_DONE;
              submit_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
